cdc_module_responder: RTL and testbench
=======================================

// Module: cdc_module_responder
// PURPOSE
//  Module-side endpoint for one bus_cdc channel, in the destination clock domain. Decodes pulsed
//  bus transactions in its address window and forwards them to a slow user core over req/ack.
//  Holds module_busy_o high until the user core acks or a timeout fires, then returns read data.
//  Also owns one local status register (sticky timeout/overrun flags, write-1-to-clear).
// PARAMETERS
//  BASE_ADDR       0            byte address of window start; window must not contain address 0
//  SPAN            'h40         window size in bytes (power of 2, >= 8)
//  STATUS_OFFSET   'h3C         byte offset of local status register inside window (word aligned)
//  TIMEOUT_CYCLES  256          WAIT_ACK cycles before forced completion (>= 2)
//  TIMEOUT_DATA    'hDEAD_BEEF  read data returned on timeout
// PORTS
//  clk_i           in   1                module clock (same clock as the bus_cdc channel's cdc_clks_i entry)
//  reset_n_i       in   1                synchronous, active-low reset
//  bus_we_i        in   1                write strobe, valid only in the pulse cycle
//  bus_we_ram_i    in   4                byte enables, valid only in the pulse cycle
//  bus_address_i   in   address_width    '0 when idle; non-zero for exactly one cycle per transaction
//  bus_data_i      in   data_width       write data, valid only in the pulse cycle
//  bus_data_o      out  data_width       read data returned to bus_cdc
//  module_busy_o   out  1                high while a transaction is in progress
//  user_req_o      out  1                request to user core
//  user_we_o       out  1                write flag (held with req)
//  user_be_o       out  4                byte enables (held with req)
//  user_addr_o     out  $clog2(SPAN)     byte offset into window (held with req)
//  user_wdata_o    out  data_width       write data (held with req)
//  user_ack_i      in   1                user core completion, single-cycle pulse
//  user_rdata_i    in   data_width       read data, valid in the cycle user_ack_i is high
//  timeout_o       out  1                sticky: a timeout has occurred
//  overrun_o       out  1                sticky: a pulse arrived while busy
// BEHAVIOUR
//  - Reset (reset_n_i=0 at a clk_i edge): state IDLE; all outputs 0; timeout counter 0. Reset mid-op
//    aborts with no completion, and user_req_o drops the next cycle.
//  - Hit: BASE_ADDR <= bus_address_i < BASE_ADDR+SPAN, sampled every cycle. Misses are ignored.
//  - FSM states: IDLE, WAIT_ACK, LOCAL.
//  - IDLE + hit at cycle T: latch we/be/offset/wdata. At T+1, module_busy_o=1 and state becomes
//    LOCAL if offset==STATUS_OFFSET, else WAIT_ACK with user_req_o=1. bus_data_o keeps its old value.
//  - LOCAL (one cycle, T+1): read: bus_data_o <= {'0, overrun, timeout}. Write: bit0/bit1 of wdata
//    clear timeout/overrun, and bus_data_o <= 0. State returns to IDLE; busy=0 at T+2.
//  - WAIT_ACK: counter increments each cycle. If user_ack_i=1: bus_data_o <= we ? 0 : user_rdata_i;
//    go to IDLE; busy and req drop the next cycle. Otherwise, if counter == TIMEOUT_CYCLES-1:
//    bus_data_o <= we ? 0 : TIMEOUT_DATA; set timeout_o; go to IDLE.
//  - If ack and timeout occur in the same cycle, ack wins and timeout_o is not set.
//  - Busy is high for >= 1 cycle per transaction, so bus_cdc always sees a falling edge.
//  - bus_data_o is stable from the completion edge until the next accepted hit. bus_cdc samples it
//    1-2 cycles after busy falls.
//  - Hit while not IDLE: dropped, overrun_o set. A hit in the LOCAL cycle is also dropped.
//  - user_ack_i in IDLE or LOCAL: ignored.
//  - Set and clear of a flag in the same cycle: set wins.
//  - Counter is $clog2(TIMEOUT_CYCLES) bits wide, cleared on entry to WAIT_ACK, never wraps.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - cpu_reg_package: address_width/data_width (existing), plus new constants STATUS_TIMEOUT_BIT=0
//    and STATUS_OVERRUN_BIT=1.
//  - Local: state enum typedef and latched-request struct {we, be, offset, wdata}.
//  - One sub-module: bus_timeout_counter (clear, enable, terminal-count pulse).
//  - Everything else is flat in this module.
// TESTING (BASE_ADDR='h9000, SPAN='h40, TIMEOUT_CYCLES=8)
//  1. Read pulse 'h9004; ack with rdata 'h1234_5678 two cycles after req rises. Expect: req high 3
//     cycles, user_addr_o='h04, busy high 3 cycles, bus_data_o='h1234_5678 held until the next hit.
//  2. Write pulse 'h9008 data 'hA5A5_0000, be='b1100; ack in the first WAIT_ACK cycle. Expect:
//     user_we_o=1, user_be_o='b1100, busy high exactly 1 cycle, bus_data_o=0.
//  3. Read 'h9010 with no ack. Expect: busy high 8 cycles, bus_data_o='hDEAD_BEEF, timeout_o=1.
//     Read 'h903C -> 'h1 with no user_req_o. Write 'h903C data 'h1 -> timeout_o=0.
//  4. Ack in the exact cycle the counter hits 7. Expect: rdata returned, timeout_o stays 0.
//  5. Second pulse 'h9014 during WAIT_ACK. Expect: dropped, overrun_o=1, the first transaction
//     completes normally. Pulse 'hA000 -> no req, no busy.
//  6. reset_n_i low for 1 cycle mid WAIT_ACK. Expect: all outputs 0 next cycle. A fresh read
//     afterwards completes normally.

Source files
------------

// File: rtl/cdc_module_responder_pkg.sv
// Shared constants, types and helpers for the module-side bus_cdc responder.
package cdc_module_responder_pkg;

   localparam int unsigned address_width      = 32;
   localparam int unsigned data_width         = 32;

   // Bit positions inside the local status register
   localparam int unsigned STATUS_TIMEOUT_BIT = 0;
   localparam int unsigned STATUS_OVERRUN_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_LOCAL    = 2'd2
   } resp_state_e;

   // Builds the read value of the local status register from the two sticky flags
   function automatic logic [data_width-1:0] status_word(input logic overrun, input logic timeout);
      logic [data_width-1:0] w;
      w                     = '0;
      w[STATUS_TIMEOUT_BIT] = timeout;
      w[STATUS_OVERRUN_BIT] = overrun;
      return w;
   endfunction

endpackage

// File: rtl/cdc_module_responder_if.sv
// Pulsed bus between a bus_cdc channel (master) and a module endpoint (slave).
interface cdc_module_responder_if;
   import cdc_module_responder_pkg::*;

   logic                     bus_we;
   logic [3:0]               bus_we_ram;
   logic [address_width-1:0] bus_address;
   logic [data_width-1:0]    bus_wdata;
   logic [data_width-1:0]    bus_rdata;
   logic                     module_busy;

   modport master (
      output bus_we, bus_we_ram, bus_address, bus_wdata,
      input  bus_rdata, module_busy
   );

   modport slave (
      input  bus_we, bus_we_ram, bus_address, bus_wdata,
      output bus_rdata, module_busy
   );

endinterface

// File: rtl/cdc_module_responder_timeout.sv
// Timeout counter for WAIT_ACK: cleared while idle, counts while enabled, saturates at the
// terminal value and flags the terminal cycle.
module bus_timeout_counter #(
   parameter int unsigned TERMINAL = 32'd256
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned    CNT_W = (TERMINAL > 32'd1) ? $clog2(TERMINAL) : 32'd1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 32'd1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority, then increment while enabled, holding at the terminal value
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Terminal-count pulse, only meaningful while counting
   always_comb begin
      tc_o = 1'b0;
      if (en_i && (cnt_q == LAST)) begin
         tc_o = 1'b1;
      end else begin
         tc_o = 1'b0;
      end
   end

endmodule

// File: rtl/cdc_module_responder.sv
// Module-side endpoint of a bus_cdc channel: decodes pulsed transactions in its window,
// forwards them to a slow user core over req/ack, and owns a local sticky status register.
module cdc_module_responder
   import cdc_module_responder_pkg::*;
#(
   parameter logic [address_width-1:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned              SPAN           = 32'h40,
   parameter int unsigned              STATUS_OFFSET  = 32'h3C,
   parameter int unsigned              TIMEOUT_CYCLES = 32'd256,
   parameter logic [data_width-1:0]    TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   cdc_module_responder_if.slave     bus_io,
   output logic                      user_req_o,
   output logic                      user_we_o,
   output logic [3:0]                user_be_o,
   output logic [$clog2(SPAN)-1:0]   user_addr_o,
   output logic [data_width-1:0]     user_wdata_o,
   input  logic                      user_ack_i,
   input  logic [data_width-1:0]     user_rdata_i,
   output logic                      timeout_o,
   output logic                      overrun_o
);

   localparam int unsigned               OFF_W      = $clog2(SPAN);
   localparam logic [OFF_W-1:0]          STATUS_OFF = OFF_W'(STATUS_OFFSET);
   localparam logic [address_width-1:0]  END_ADDR   = BASE_ADDR + address_width'(SPAN);

   // Request captured in the pulse cycle and held towards the user core
   typedef struct packed {
      logic                  we;
      logic [3:0]            be;
      logic [OFF_W-1:0]      offset;
      logic [data_width-1:0] wdata;
   } req_t;

   resp_state_e            state_q;
   req_t                   req_q;
   logic                   busy_q;
   logic                   user_req_q;
   logic                   timeout_q;
   logic                   overrun_q;
   logic [data_width-1:0]  bus_data_q;

   logic                   hit_s;
   logic [OFF_W-1:0]       offset_s;
   logic                   cnt_clr_s;
   logic                   cnt_en_s;
   logic                   cnt_tc_s;

   // Window decode of the pulsed address and its byte offset inside the window
   always_comb begin
      hit_s    = 1'b0;
      offset_s = OFF_W'(bus_io.bus_address - BASE_ADDR);
      if ((bus_io.bus_address >= BASE_ADDR) && (bus_io.bus_address < END_ADDR)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
   end

   // The timeout counter runs only in WAIT_ACK, so it is always zero on entry
   always_comb begin
      cnt_en_s  = 1'b0;
      cnt_clr_s = 1'b1;
      if (state_q == ST_WAIT_ACK) begin
         cnt_en_s  = 1'b1;
         cnt_clr_s = 1'b0;
      end else begin
         cnt_en_s  = 1'b0;
         cnt_clr_s = 1'b1;
      end
   end

   bus_timeout_counter #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clr_i     (cnt_clr_s),
      .en_i      (cnt_en_s),
      .tc_o      (cnt_tc_s)
   );

   // Transaction FSM with all outputs registered; overrun set is applied last so it beats a clear
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         busy_q     <= 1'b0;
         user_req_q <= 1'b0;
         bus_data_q <= '0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (hit_s) begin
                  req_q.we     <= bus_io.bus_we;
                  req_q.be     <= bus_io.bus_we_ram;
                  req_q.offset <= offset_s;
                  req_q.wdata  <= bus_io.bus_wdata;
                  busy_q       <= 1'b1;
                  if (offset_s == STATUS_OFF) begin
                     state_q    <= ST_LOCAL;
                     user_req_q <= 1'b0;
                  end else begin
                     state_q    <= ST_WAIT_ACK;
                     user_req_q <= 1'b1;
                  end
               end else begin
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  user_req_q <= 1'b0;
               end
            end
            ST_LOCAL: begin
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               user_req_q <= 1'b0;
               if (req_q.we) begin
                  bus_data_q <= '0;
                  if (req_q.wdata[STATUS_TIMEOUT_BIT]) begin
                     timeout_q <= 1'b0;
                  end
                  if (req_q.wdata[STATUS_OVERRUN_BIT]) begin
                     overrun_q <= 1'b0;
                  end
               end else begin
                  bus_data_q <= status_word(overrun_q, timeout_q);
               end
            end
            ST_WAIT_ACK: begin
               if (user_ack_i) begin
                  bus_data_q <= req_q.we ? '0 : user_rdata_i;
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  user_req_q <= 1'b0;
               end else if (cnt_tc_s) begin
                  bus_data_q <= req_q.we ? '0 : TIMEOUT_DATA;
                  timeout_q  <= 1'b1;
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  user_req_q <= 1'b0;
               end else begin
                  state_q <= ST_WAIT_ACK;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               user_req_q <= 1'b0;
            end
         endcase
         if (hit_s && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign bus_io.bus_rdata   = bus_data_q;
   assign bus_io.module_busy = busy_q;
   assign user_req_o         = user_req_q;
   assign user_we_o          = req_q.we;
   assign user_be_o          = req_q.be;
   assign user_addr_o        = req_q.offset;
   assign user_wdata_o       = req_q.wdata;
   assign timeout_o          = timeout_q;
   assign overrun_o          = overrun_q;

endmodule

// File: tb/tb_cdc_module_responder.sv
// Randomized self-checking bench for cdc_module_responder with a transaction-level model.
module tb_cdc_module_responder;
   import cdc_module_responder_pkg::*;

   localparam logic [31:0] BASE  = 32'h0000_9000;
   localparam logic [31:0] SPAN  = 32'h0000_0040;
   localparam logic [31:0] STAT  = 32'h0000_003C;
   localparam int          TC    = 8;
   localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic        user_req;
   logic        user_we;
   logic [3:0]  user_be;
   logic [5:0]  user_addr;
   logic [31:0] user_wdata;
   logic        user_ack   = 1'b0;
   logic [31:0] user_rdata = 32'h0;
   logic        timeout;
   logic        overrun;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference state: sticky flags and the data word bus_cdc should see
   logic        m_timeout = 1'b0;
   logic        m_overrun = 1'b0;
   logic [31:0] m_data    = 32'h0;

   cdc_module_responder_if bus_if();

   cdc_module_responder #(
      .BASE_ADDR      (32'h0000_9000),
      .SPAN           (32'h40),
      .STATUS_OFFSET  (32'h3C),
      .TIMEOUT_CYCLES (32'd8),
      .TIMEOUT_DATA   (32'hDEAD_BEEF)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .bus_io       (bus_if),
      .user_req_o   (user_req),
      .user_we_o    (user_we),
      .user_be_o    (user_be),
      .user_addr_o  (user_addr),
      .user_wdata_o (user_wdata),
      .user_ack_i   (user_ack),
      .user_rdata_i (user_rdata),
      .timeout_o    (timeout),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"},  {31'h0, bus_if.module_busy}, 32'h0);
      check_val({tag, "_req"},   {31'h0, user_req}, 32'h0);
      check_val({tag, "_we"},    {31'h0, user_we}, 32'h0);
      check_val({tag, "_be"},    {28'h0, user_be}, 32'h0);
      check_val({tag, "_addr"},  {26'h0, user_addr}, 32'h0);
      check_val({tag, "_wdata"}, user_wdata, 32'h0);
      check_val({tag, "_data"},  bus_if.bus_rdata, 32'h0);
      check_val({tag, "_tmo"},   {31'h0, timeout}, 32'h0);
      check_val({tag, "_ovr"},   {31'h0, overrun}, 32'h0);
   endtask

   // One pulsed transaction. ack_d: ack this many cycles after req rises (<0: never).
   // hit_k: extra in-window pulse in the k-th busy cycle (0: none).
   task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input int ack_d, input int hit_k,
                          input logic [31:0] rdata);
      logic        is_hit, is_local, acked, done;
      logic [31:0] off, old_data, new_data;
      int          exp_busy, exp_req, busy_seen, req_seen, hk;

      is_hit   = (addr >= BASE) && (addr < BASE + SPAN);
      off      = addr - BASE;
      is_local = is_hit && (off == STAT);
      acked    = 1'b0;
      if (!is_hit) begin
         exp_busy = 0; exp_req = 0;
      end else if (is_local) begin
         exp_busy = 1; exp_req = 0;
      end else if (ack_d >= 0 && ack_d < TC) begin
         exp_busy = ack_d + 1; exp_req = exp_busy; acked = 1'b1;
      end else begin
         exp_busy = TC; exp_req = TC;
      end
      hk = (hit_k >= 1 && hit_k <= exp_busy) ? hit_k : 0;

      old_data = m_data;
      new_data = m_data;
      if (is_local) begin
         if (we) begin
            new_data = 32'h0;
            if (wdata[0]) m_timeout = 1'b0;
            if (wdata[1]) m_overrun = 1'b0;
         end else begin
            new_data = {30'h0, m_overrun, m_timeout};
         end
      end else if (is_hit) begin
         if (we)         new_data = 32'h0;
         else if (acked) new_data = rdata;
         else            new_data = TDATA;
         if (!acked) m_timeout = 1'b1;
      end
      if (hk != 0) m_overrun = 1'b1;

      @(negedge clk);
      bus_if.bus_address = addr;
      bus_if.bus_we      = we;
      bus_if.bus_we_ram  = be;
      bus_if.bus_wdata   = wdata;
      done      = 1'b0;
      busy_seen = 0;
      req_seen  = 0;
      for (int k = 1; k <= TC + 4 && !done; k++) begin
         @(negedge clk);
         bus_if.bus_address = 32'h0;
         bus_if.bus_we      = 1'($urandom);
         bus_if.bus_we_ram  = 4'($urandom);
         bus_if.bus_wdata   = $urandom;
         user_ack           = 1'b0;
         user_rdata         = $urandom;
         if (k == 1 && is_hit) begin
            check_val("data_kept_at_accept", bus_if.bus_rdata, old_data);
            if (!is_local) begin
               check_val("user_addr",  {26'h0, user_addr}, off & 32'h3F);
               check_val("user_we",    {31'h0, user_we}, {31'h0, we});
               check_val("user_be",    {28'h0, user_be}, {28'h0, be});
               check_val("user_wdata", user_wdata, wdata);
            end
         end
         if (bus_if.module_busy) busy_seen++;
         if (user_req)           req_seen++;
         if (!bus_if.module_busy) begin
            done = 1'b1;
         end else begin
            if (acked && (k - 1 == ack_d)) begin
               user_ack   = 1'b1;
               user_rdata = rdata;
            end else if (is_local && ack_d == 0) begin
               user_ack = 1'b1;
            end
            if (k == hk) bus_if.bus_address = BASE + ($urandom_range(0, 15) << 2);
         end
      end
      check_val("busy_falls", {31'h0, done}, 32'h1);
      m_data = new_data;
      check_val("busy_cycles", busy_seen, exp_busy);
      check_val("req_cycles",  req_seen,  exp_req);
      check_val("bus_data",    bus_if.bus_rdata, m_data);
      check_val("timeout_o",   {31'h0, timeout}, {31'h0, m_timeout});
      check_val("overrun_o",   {31'h0, overrun}, {31'h0, m_overrun});

      // Idle gap with a possible stray ack that must be ignored
      @(negedge clk);
      user_ack   = 1'($urandom);
      user_rdata = $urandom;
      @(negedge clk);
      user_ack = 1'b0;
      check_val("hold_data", bus_if.bus_rdata, m_data);
      check_val("idle_busy", {31'h0, bus_if.module_busy}, 32'h0);
   endtask

   initial begin
      logic [31:0] addr;
      int          sel, r, ack_d, hit_k;

      bus_if.bus_address = 32'h0;
      bus_if.bus_we      = 1'b0;
      bus_if.bus_we_ram  = 4'h0;
      bus_if.bus_wdata   = 32'h0;
      reset_n            = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;

      // Read with ack two cycles after req
      run_txn(BASE + 32'h04, 1'b0, 4'hF, 32'h0, 2, 0, 32'h1234_5678);
      // Write acked in the first WAIT_ACK cycle
      run_txn(BASE + 32'h08, 1'b1, 4'b1100, 32'hA5A5_0000, 0, 0, 32'h5555_AAAA);
      // Timeout, then status read (with an ignored ack) and clear
      run_txn(BASE + 32'h10, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0);
      run_txn(BASE + STAT,   1'b0, 4'hF, 32'h0, 0, 0, 32'h0);
      run_txn(BASE + STAT,   1'b1, 4'hF, 32'h1, -1, 0, 32'h0);
      // Ack on the last counter value wins over the timeout
      run_txn(BASE + 32'h18, 1'b0, 4'hF, 32'h0, TC - 1, 0, 32'hCAFE_F00D);
      // Overrun during WAIT_ACK, then a miss
      run_txn(BASE + 32'h20, 1'b0, 4'hF, 32'h0, 3, 2, 32'h0BAD_F00D);
      run_txn(32'h0000_A000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0);

      // Reset in the middle of WAIT_ACK
      @(negedge clk);
      bus_if.bus_address = BASE + 32'h10;
      bus_if.bus_we      = 1'b0;
      @(negedge clk);
      bus_if.bus_address = 32'h0;
      repeat (2) @(negedge clk);
      check_val("pre_reset_req", {31'h0, user_req}, 32'h1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_all_zero("mid_reset");
      m_timeout = 1'b0;
      m_overrun = 1'b0;
      m_data    = 32'h0;
      run_txn(BASE + 32'h0C, 1'b0, 4'hF, 32'h0, 1, 0, 32'h7777_1111);

      // Randomized transactions
      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 2)       addr = BASE + STAT;
         else if (sel == 2) addr = BASE + SPAN + ($urandom_range(0, 63) << 2);
         else if (sel == 3) addr = BASE - ($urandom_range(1, 64) << 2);
         else               addr = BASE + ($urandom_range(0, 14) << 2);
         r     = int'($urandom_range(0, 11));
         ack_d = (r >= TC + 2) ? -1 : r;
         hit_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TC)) : 0;
         run_txn(addr, 1'($urandom), 4'($urandom), $urandom, ack_d, hit_k, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
